// File: rtl/fpu_issue_queue.sv
// Issue queue in front of the non-stalling double-precision FPU: buffers requests, keeps one op in flight,
// returns tagged results and accumulates fflags. Define FPU_ISSUE_WATCHDOG_EN to add a WAIT-state timeout.
module fpu_issue_queue #(
  parameter int depth_log2 = 2,
  parameter int tag_width  = 6,
  parameter int ivec_width = 10
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_flush,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ivec_width-1:0] i_req_ivec,
  input  logic [63:0]           i_req_a,
  input  logic [63:0]           i_req_b,
  input  logic [tag_width-1:0]  i_req_tag,
  output logic                  o_fpu_ena,
  output logic [ivec_width-1:0] o_fpu_ivec,
  output logic [63:0]           o_fpu_a,
  output logic [63:0]           o_fpu_b,
  input  logic [63:0]           i_fpu_res,
  input  logic [4:0]            i_fpu_ex,
  input  logic                  i_fpu_valid,
  output logic                  o_resp_valid,
  output logic [tag_width-1:0]  o_resp_tag,
  output logic [63:0]           o_resp_res,
  output logic [4:0]            o_resp_fflags,
  input  logic                  i_fflags_clr,
  output logic [4:0]            o_fflags_acc,
  output logic                  o_busy
);

  // state | meaning
  // IDLE  | no op in flight; issues queue head when queue non-empty and no flush
  // WAIT  | one op in flight; waits for i_fpu_valid (or watchdog expiry)

  localparam int depth = 1 << depth_log2;

  typedef logic [depth_log2-1:0] ptr_t;
  typedef logic [depth_log2:0]   cnt_t;
  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

  typedef struct packed {
    logic [ivec_width-1:0] ivec;
    logic [63:0]           a;
    logic [63:0]           b;
    logic [tag_width-1:0]  tag;
  } entry_t;

  localparam cnt_t full_cnt = cnt_t'(depth);

  entry_t                mem_q [depth];
  entry_t                mem_d [depth];
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  count_q, count_d;
  state_t                state_q, state_d;
  logic                  discard_q, discard_d;
  logic [tag_width-1:0]  tag_inflight_q, tag_inflight_d;
  logic                  fpu_ena_q, fpu_ena_d;
  logic [ivec_width-1:0] fpu_ivec_q, fpu_ivec_d;
  logic [63:0]           fpu_a_q, fpu_a_d;
  logic [63:0]           fpu_b_q, fpu_b_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [tag_width-1:0]  resp_tag_q, resp_tag_d;
  logic [63:0]           resp_res_q, resp_res_d;
  logic [4:0]            resp_fflags_q, resp_fflags_d;
  logic [4:0]            fflags_acc_q, fflags_acc_d;
`ifdef FPU_ISSUE_WATCHDOG_EN
  logic [7:0]            wdog_q, wdog_d;
`endif

  logic push;
  logic pop;
  logic op_done;
  logic timeout;

  assign o_req_ready = (count_q != full_cnt) && !i_flush;
  assign push        = i_req_valid && o_req_ready;

  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    state_d        = state_q;
    discard_d      = discard_q;
    tag_inflight_d = tag_inflight_q;
    fpu_ena_d      = 1'b0;
    fpu_ivec_d     = fpu_ivec_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    resp_valid_d   = 1'b0;
    resp_tag_d     = resp_tag_q;
    resp_res_d     = resp_res_q;
    resp_fflags_d  = resp_fflags_q;
    pop            = 1'b0;
    timeout        = 1'b0;
    op_done        = 1'b0;
`ifdef FPU_ISSUE_WATCHDOG_EN
    wdog_d         = wdog_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = '{ivec: i_req_ivec, a: i_req_a, b: i_req_b, tag: i_req_tag};
    end

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0 && !i_flush) begin
          pop            = 1'b1;
          fpu_ena_d      = 1'b1;
          fpu_ivec_d     = mem_q[rd_ptr_q].ivec;
          fpu_a_d        = mem_q[rd_ptr_q].a;
          fpu_b_d        = mem_q[rd_ptr_q].b;
          tag_inflight_d = mem_q[rd_ptr_q].tag;
          discard_d      = 1'b0;
          state_d        = ST_WAIT;
`ifdef FPU_ISSUE_WATCHDOG_EN
          // 254..0 inclusive gives 255 WAIT cycles before expiry
          wdog_d         = 8'd254;
`endif
        end
      end
      ST_WAIT: begin
`ifdef FPU_ISSUE_WATCHDOG_EN
        timeout = !i_fpu_valid && (wdog_q == 8'd0);
        if (!i_fpu_valid && wdog_q != 8'd0) begin
          wdog_d = wdog_q - 8'd1;
        end
`endif
        op_done = i_fpu_valid || timeout;
        if (op_done) begin
          // A flush in the completion cycle kills the result as well
          if (!discard_q && !i_flush) begin
            resp_valid_d  = 1'b1;
            resp_tag_d    = tag_inflight_q;
            resp_res_d    = timeout ? 64'd0 : i_fpu_res;
            resp_fflags_d = timeout ? 5'b10000 : i_fpu_ex;
          end
          discard_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (i_flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + ptr_t'(push);
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
      count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
    end

    fflags_acc_d = (i_fflags_clr ? 5'b0 : fflags_acc_q) | (resp_valid_d ? resp_fflags_d : 5'b0);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_IDLE;
      discard_q      <= 1'b0;
      tag_inflight_q <= '0;
      fpu_ena_q      <= 1'b0;
      fpu_ivec_q     <= '0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_tag_q     <= '0;
      resp_res_q     <= '0;
      resp_fflags_q  <= '0;
      fflags_acc_q   <= '0;
`ifdef FPU_ISSUE_WATCHDOG_EN
      wdog_q         <= '0;
`endif
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      discard_q      <= discard_d;
      tag_inflight_q <= tag_inflight_d;
      fpu_ena_q      <= fpu_ena_d;
      fpu_ivec_q     <= fpu_ivec_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      resp_valid_q   <= resp_valid_d;
      resp_tag_q     <= resp_tag_d;
      resp_res_q     <= resp_res_d;
      resp_fflags_q  <= resp_fflags_d;
      fflags_acc_q   <= fflags_acc_d;
`ifdef FPU_ISSUE_WATCHDOG_EN
      wdog_q         <= wdog_d;
`endif
    end
  end

  assign o_fpu_ena     = fpu_ena_q;
  assign o_fpu_ivec    = fpu_ivec_q;
  assign o_fpu_a       = fpu_a_q;
  assign o_fpu_b       = fpu_b_q;
  assign o_resp_valid  = resp_valid_q;
  assign o_resp_tag    = resp_tag_q;
  assign o_resp_res    = resp_res_q;
  assign o_resp_fflags = resp_fflags_q;
  assign o_fflags_acc  = fflags_acc_q;
  assign o_busy        = (count_q != '0) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Scoreboard bench for fpu_issue_queue: stimulus queues expected issues/responses, an FPU model answers
// issues, and a monitor checks every o_resp_valid against the scoreboard.
module tb_fpu_issue_queue;
  localparam int TW = 6;
  localparam int IW = 10;

  logic          i_clk = 1'b0;
  logic          i_nrst = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [IW-1:0] i_req_ivec = '0;
  logic [63:0]   i_req_a = '0;
  logic [63:0]   i_req_b = '0;
  logic [TW-1:0] i_req_tag = '0;
  logic          o_fpu_ena;
  logic [IW-1:0] o_fpu_ivec;
  logic [63:0]   o_fpu_a;
  logic [63:0]   o_fpu_b;
  logic [63:0]   i_fpu_res;
  logic [4:0]    i_fpu_ex;
  logic          i_fpu_valid;
  logic          o_resp_valid;
  logic [TW-1:0] o_resp_tag;
  logic [63:0]   o_resp_res;
  logic [4:0]    o_resp_fflags;
  logic          i_fflags_clr;
  logic [4:0]    o_fflags_acc;
  logic          o_busy;

  fpu_issue_queue #(.depth_log2(2), .tag_width(TW), .ivec_width(IW)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_ivec(i_req_ivec),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_tag(i_req_tag),
    .o_fpu_ena(o_fpu_ena), .o_fpu_ivec(o_fpu_ivec), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b),
    .i_fpu_res(i_fpu_res), .i_fpu_ex(i_fpu_ex), .i_fpu_valid(i_fpu_valid),
    .o_resp_valid(o_resp_valid), .o_resp_tag(o_resp_tag), .o_resp_res(o_resp_res),
    .o_resp_fflags(o_resp_fflags), .i_fflags_clr(i_fflags_clr), .o_fflags_acc(o_fflags_acc),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {logic [TW-1:0] tag; logic [63:0] res; logic [4:0] ff; bit by_valid;} resp_t;
  typedef struct {logic [IW-1:0] ivec; logic [63:0] a; logic [63:0] b;} iss_t;
  typedef struct {logic [63:0] res; logic [4:0] ex; int delay; bit clr;} fpu_t;

  resp_t sb_q[$];
  iss_t  iss_q[$];
  fpu_t  fpu_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    fpu_hold = 1'b0;
  bit    fpu_busy = 1'b0;
  logic  vld_prev = 1'b0;
  bit    pushed5;

  localparam logic [IW-1:0] FADD = 10'b00_0000_0001;

  always @(posedge i_clk) vld_prev <= i_fpu_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Queue the expected issue, the FPU answer and (optionally) the expected writeback response
  task automatic expect_op(input logic [TW-1:0] tag, input logic [IW-1:0] ivec, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] res, input logic [4:0] ex,
                           input int delay, input bit clr, input bit want_resp);
    iss_q.push_back('{ivec: ivec, a: a, b: b});
    fpu_q.push_back('{res: res, ex: ex, delay: delay, clr: clr});
    if (want_resp) sb_q.push_back('{tag: tag, res: res, ff: ex, by_valid: 1'b1});
  endtask

  task automatic push_req(input logic [TW-1:0] tag, input logic [IW-1:0] ivec, input logic [63:0] a,
                          input logic [63:0] b);
    int n = 0;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_tag = tag; i_req_ivec = ivec; i_req_a = a; i_req_b = b;
    #1;
    while (!o_req_ready && n < 1000) begin
      @(negedge i_clk); #1; n++;
    end
    if (n >= 1000) check("push_timeout", 64'(o_req_ready), 64'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || o_busy || fpu_busy) && n < budget) begin
      @(negedge i_clk); n++;
    end
    if (n >= budget) check("idle_timeout", 64'(o_busy), 64'd0);
    repeat (2) @(negedge i_clk);
  endtask

  // FPU model: answers each o_fpu_ena after the queued delay with a one-cycle i_fpu_valid
  initial begin
    fpu_t f;
    iss_t s;
    int   n;
    i_fpu_valid = 1'b0; i_fpu_res = '0; i_fpu_ex = '0; i_fflags_clr = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_fpu_ena) begin
        if (iss_q.size() == 0 || fpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue a=%h b=%h", o_fpu_a, o_fpu_b);
        end else begin
          s = iss_q.pop_front();
          f = fpu_q.pop_front();
          fpu_busy = 1'b1;
          check("issue_ivec", 64'(o_fpu_ivec), 64'(s.ivec));
          check("issue_a", o_fpu_a, s.a);
          check("issue_b", o_fpu_b, s.b);
          for (int i = 0; i < f.delay; i++) begin
            @(negedge i_clk);
            if (i == 0) check("ena_pulse", 64'(o_fpu_ena), 64'd0);
          end
          n = 0;
          while (fpu_hold && n < 2000) begin
            @(negedge i_clk); n++;
          end
          i_fpu_valid = 1'b1; i_fpu_res = f.res; i_fpu_ex = f.ex; i_fflags_clr = f.clr;
          @(negedge i_clk);
          i_fpu_valid = 1'b0; i_fflags_clr = 1'b0;
          fpu_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: every writeback response must match the head of the scoreboard
  initial begin
    resp_t e;
    forever begin
      @(negedge i_clk);
      if (i_nrst && o_resp_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp tag=%h res=%h", o_resp_tag, o_resp_res);
        end else begin
          e = sb_q.pop_front();
          check("resp_tag", 64'(o_resp_tag), 64'(e.tag));
          check("resp_res", o_resp_res, e.res);
          check("resp_fflags", 64'(o_resp_fflags), 64'(e.ff));
          if (e.by_valid) check("resp_latency", 64'(vld_prev), 64'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_ready", 64'(o_req_ready), 64'd1);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("rst_fpu_ena", 64'(o_fpu_ena), 64'd0);
    check("rst_acc", 64'(o_fflags_acc), 64'd0);
    i_nrst = 1'b1;
    @(negedge i_clk);

    // Single op: 1.0 + 2.0 = 3.0
    expect_op(6'd5, FADD, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'd0, 4, 0, 1);
    push_req(6'd5, FADD, 64'h3FF0000000000000, 64'h4000000000000000);
    wait_idle(200);
    check("single_acc", 64'(o_fflags_acc), 64'd0);

    // fflags accumulation, then clear coincident with a new flag
    expect_op(6'd1, 10'h002, 64'h11, 64'h12, 64'hA1, 5'b00001, 2, 0, 1);
    expect_op(6'd2, 10'h004, 64'h21, 64'h22, 64'hA2, 5'b00100, 3, 0, 1);
    push_req(6'd1, 10'h002, 64'h11, 64'h12);
    push_req(6'd2, 10'h004, 64'h21, 64'h22);
    wait_idle(200);
    check("acc_or", 64'(o_fflags_acc), 64'h05);
    expect_op(6'd3, 10'h008, 64'h31, 64'h32, 64'hA3, 5'b10000, 2, 1, 1);
    push_req(6'd3, 10'h008, 64'h31, 64'h32);
    wait_idle(200);
    check("acc_clr_same_cycle", 64'(o_fflags_acc), 64'h10);

    // Full: tag0 in flight plus four queued fills the queue; tag5 waits for the first response
    fpu_hold = 1'b1;
    for (int i = 0; i < 6; i++)
      expect_op(TW'(i), FADD, 64'h100 + 64'(i), 64'h200 + 64'(i), 64'h300 + 64'(i), 5'd0, 1, 0, 1);
    for (int i = 0; i < 5; i++)
      push_req(TW'(i), FADD, 64'h100 + 64'(i), 64'h200 + 64'(i));
    @(negedge i_clk); #1;
    check("full_ready", 64'(o_req_ready), 64'd0);
    check("full_busy", 64'(o_busy), 64'd1);
    pushed5 = 1'b0;
    fork
      begin
        push_req(6'd5, FADD, 64'h105, 64'h205);
        pushed5 = 1'b1;
      end
      begin
        repeat (6) @(negedge i_clk);
        check("full_blocks_push", 64'(pushed5), 64'd0);
        fpu_hold = 1'b0;
      end
    join
    wait_idle(500);

    // Flush while tag3 is in flight with two ops queued: nothing comes back
    expect_op(6'd3, FADD, 64'h333, 64'h444, 64'h555, 5'b00001, 20, 0, 0);
    push_req(6'd3, FADD, 64'h333, 64'h444);
    push_req(6'd8, FADD, 64'h888, 64'h888);
    push_req(6'd9, FADD, 64'h999, 64'h999);
    @(negedge i_clk);
    i_flush = 1'b1; i_req_valid = 1'b1; i_req_tag = 6'd10; #1;
    check("flush_ready", 64'(o_req_ready), 64'd0);
    @(negedge i_clk);
    i_flush = 1'b0; i_req_valid = 1'b0;
    check("flush_busy_wait", 64'(o_busy), 64'd1);
    begin
      int n = 0;
      do begin
        @(posedge i_clk); n++;
      end while (!i_fpu_valid && n < 100);
      if (n >= 100) check("flush_valid_timeout", 64'(i_fpu_valid), 64'd1);
    end
    @(negedge i_clk);
    check("flush_busy_after", 64'(o_busy), 64'd0);
    check("flush_no_resp", 64'(o_resp_valid), 64'd0);
    wait_idle(100);

    // Wrap: ten ops through the four-entry queue, in order
    for (int i = 0; i < 10; i++)
      expect_op(TW'(10 + i), IW'(1 << i), 64'h1000 + 64'(i), 64'h2000 + 64'(i),
                64'h4000000000000000 + 64'(i), 5'd0, 1 + (i % 3), 0, 1);
    for (int i = 0; i < 10; i++)
      push_req(TW'(10 + i), IW'(1 << i), 64'h1000 + 64'(i), 64'h2000 + 64'(i));
    wait_idle(1000);
    check("acc_hold", 64'(o_fflags_acc), 64'h10);

    // Reset mid-operation; the late FPU answer arrives in IDLE and is ignored
    expect_op(6'd1, FADD, 64'h77, 64'h88, 64'h99, 5'b00010, 12, 0, 0);
    push_req(6'd1, FADD, 64'h77, 64'h88);
    repeat (3) @(negedge i_clk);
    i_nrst = 1'b0;
    @(negedge i_clk);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_ready", 64'(o_req_ready), 64'd1);
    check("midrst_acc", 64'(o_fflags_acc), 64'd0);
    i_nrst = 1'b1;
    wait_idle(100);
    check("midrst_acc_after", 64'(o_fflags_acc), 64'd0);

`ifdef FPU_ISSUE_WATCHDOG_EN
    // Watchdog: FPU answers far too late; timeout response then the late answer is ignored
    iss_q.push_back('{ivec: FADD, a: 64'h5, b: 64'h6});
    fpu_q.push_back('{res: 64'hDEAD, ex: 5'b00001, delay: 300, clr: 1'b0});
    sb_q.push_back('{tag: 6'd7, res: 64'd0, ff: 5'b10000, by_valid: 1'b0});
    push_req(6'd7, FADD, 64'h5, 64'h6);
    wait_idle(600);
    check("wdog_acc", 64'(o_fflags_acc), 64'h10);
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("iss_drained", 64'(iss_q.size()), 64'd0);
    check("fpu_drained", 64'(fpu_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
